// File: rtl/stack_sequencer.sv
// Register save/restore sequencer: a push copies NUM_REGS registers onto a word stack, a pop restores them in reverse order.
// Optional macro STACK_SEQ_GUARD_EN enables full/empty rejection and the sticky overflow/underflow flags.
module stack_sequencer #(
  parameter int DATA_WIDTH     = 8,
  parameter int NUM_REGS       = 4,
  parameter int REG_ADDR_WIDTH = 2,
  parameter int STACK_DEPTH    = 16,
  parameter int SP_WIDTH       = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic                      pop,
  input  logic [DATA_WIDTH-1:0]     reg_rd_data,
  output logic [REG_ADDR_WIDTH-1:0] reg_addr,
  output logic                      reg_wr_en,
  output logic [DATA_WIDTH-1:0]     reg_wr_data,
  output logic                      stall,
  output logic                      busy,
  output logic [SP_WIDTH-1:0]       sp,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [REG_ADDR_WIDTH-1:0] CNT_LAST = REG_ADDR_WIDTH'(NUM_REGS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PUSH = 2'd1,
    POP  = 2'd2
  } state_t;

  state_t                    state_q, state_n;
  logic [REG_ADDR_WIDTH-1:0] cnt_q, cnt_n;
  logic [SP_WIDTH-1:0]       sp_q, sp_n;
  logic [SP_WIDTH-1:0]       sp_inc, sp_dec;
  logic                      ovf_q, ovf_n;
  logic                      unf_q, unf_n;
  logic                      push_ok, pop_ok;
  logic [DATA_WIDTH-1:0]     stack [STACK_DEPTH];

  // Pointer arithmetic and request acceptance depend on whether the guard is built in.
  always_comb begin
`ifdef STACK_SEQ_GUARD_EN
    sp_inc  = sp_q + SP_WIDTH'(1);
    sp_dec  = sp_q - SP_WIDTH'(1);
    push_ok = push && (sp_q <= SP_WIDTH'(STACK_DEPTH - NUM_REGS));
    pop_ok  = pop && !push && (sp_q >= SP_WIDTH'(NUM_REGS));
`else
    sp_inc  = (sp_q == SP_WIDTH'(STACK_DEPTH - 1)) ? '0 : sp_q + SP_WIDTH'(1);
    sp_dec  = (sp_q == '0) ? SP_WIDTH'(STACK_DEPTH - 1) : sp_q - SP_WIDTH'(1);
    push_ok = push;
    pop_ok  = pop && !push;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sp_q    <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      sp_q    <= sp_n;
      ovf_q   <= ovf_n;
      unf_q   <= unf_n;
    end
  end

  // Stack storage carries no reset; writes only happen while a push transfer is active.
  always_ff @(posedge clk) begin
    if (state_q == PUSH) begin
      stack[IDX_W'(sp_q)] <= reg_rd_data;
    end
  end

  always_comb begin
    state_n     = state_q;
    cnt_n       = cnt_q;
    sp_n        = sp_q;
    ovf_n       = ovf_q;
    unf_n       = unf_q;
    reg_addr    = '0;
    reg_wr_en   = 1'b0;
    reg_wr_data = '0;
    stall       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (push_ok) begin
          state_n = PUSH;
          cnt_n   = '0;
          stall   = rst;
        end else if (pop_ok) begin
          state_n = POP;
          cnt_n   = CNT_LAST;
          stall   = rst;
        end
`ifdef STACK_SEQ_GUARD_EN
        if (push) begin
          if (!push_ok) ovf_n = 1'b1;
        end else if (pop && !pop_ok) begin
          unf_n = 1'b1;
        end
`endif
      end
      PUSH: begin
        reg_addr = cnt_q;
        sp_n     = sp_inc;
        if (cnt_q == CNT_LAST) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_q + REG_ADDR_WIDTH'(1);
          stall = 1'b1;
        end
      end
      POP: begin
        reg_addr    = cnt_q;
        reg_wr_en   = 1'b1;
        reg_wr_data = stack[IDX_W'(sp_dec)];
        sp_n        = sp_dec;
        if (cnt_q == '0) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt_q - REG_ADDR_WIDTH'(1);
          stall = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign sp        = sp_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule
